// File: rtl/stage_if_if.sv
// stage_if_if: fetch-stage bus bundling the imem request/response handshake and the if_id packet
//   master (fetch): drives imem_req_valid/imem_req_addr/if_packet, samples imem_req_ready/imem_resp_*
//   slave (memory/decode side): the mirror image
interface stage_if_if;
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] npc;
    logic        valid;
  } if_id_packet_t;
  logic          imem_req_valid;
  logic [31:0]   imem_req_addr;
  logic          imem_req_ready;
  logic          imem_resp_valid;
  logic [31:0]   imem_resp_data;
  if_id_packet_t if_packet;
  modport master (
    output imem_req_valid, imem_req_addr, if_packet,
    input  imem_req_ready, imem_resp_valid, imem_resp_data
  );
  modport slave (
    input  imem_req_valid, imem_req_addr, if_packet,
    output imem_req_ready, imem_resp_valid, imem_resp_data
  );
endinterface

// File: rtl/stage_if.sv
// stage_if: fetch stage holding the PC, issuing one imem request at a time and presenting if_packet
//   clock/reset: system clock, synchronous active-high reset
//   id_stall: dispatch cannot take if_packet; redirect_en/redirect_pc: retire-side flush target
//   bus: imem request/response handshake and registered if_packet
module stage_if #(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        id_stall,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  stage_if_if.master  bus
);
  localparam logic [31:0] NOP = 32'h0000_0013;
  typedef enum logic [1:0] {REQ, WAIT, HOLD, DRAIN} state_t;
  state_t      state;
  logic [31:0] pc;
  logic        outstanding;
  assign bus.imem_req_valid = state == REQ && !reset;
  assign bus.imem_req_addr  = pc;
  // a request is still in flight after this edge unless its response lands now
  assign outstanding = (state == REQ && bus.imem_req_ready) ||
                       ((state == WAIT || state == DRAIN) && !bus.imem_resp_valid);
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= REQ;
      pc            <= RESET_PC;
      bus.if_packet <= {NOP, RESET_PC, RESET_PC + PC_STEP, 1'b0};
    end else if (redirect_en) begin
      state               <= outstanding ? DRAIN : REQ;
      pc                  <= redirect_pc & ~32'd3;
      bus.if_packet.valid <= 1'b0;
      bus.if_packet.inst  <= NOP;
    end else begin
      case (state)
        REQ: if (bus.imem_req_ready) state <= WAIT;
        WAIT: if (bus.imem_resp_valid) begin
          bus.if_packet <= {bus.imem_resp_data, pc, pc + PC_STEP, 1'b1};
          pc            <= pc + PC_STEP;
          state         <= HOLD;
        end
        HOLD: if (!id_stall) begin
          bus.if_packet.valid <= 1'b0;
          bus.if_packet.inst  <= NOP;
          state               <= REQ;
        end
        DRAIN: if (bus.imem_resp_valid) state <= REQ;
      endcase
    end
  end
endmodule

// File: tb/tb_stage_if.sv
// tb_stage_if: directed self-checking bench for stage_if (default reset PC and a wrapping reset PC)
module tb_stage_if;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic        clock = 1'b0;
  logic        rst = 1'b1, stall = 1'b0, redir = 1'b0;
  logic [31:0] rpc = '0;
  logic        rst2 = 1'b1, stall2 = 1'b0;
  int          cnt = 0, errs = 0;
  stage_if_if bus ();
  stage_if_if bus2 ();
  stage_if dut (
    .clock(clock), .reset(rst), .id_stall(stall), .redirect_en(redir), .redirect_pc(rpc), .bus(bus)
  );
  stage_if #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clock(clock), .reset(rst2), .id_stall(stall2), .redirect_en(1'b0), .redirect_pc(32'h0), .bus(bus2)
  );
  always #5 clock = ~clock;
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cnt++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic fetch(input logic [31:0] data);
    bus.imem_req_ready = 1'b1;
    tick;
    bus.imem_req_ready  = 1'b0;
    bus.imem_resp_valid = 1'b1;
    bus.imem_resp_data  = data;
    tick;
    bus.imem_resp_valid = 1'b0;
    #1;
  endtask
  task automatic chk_pkt(input string tag, input logic [31:0] inst, input logic [31:0] pc,
                         input logic [31:0] npc, input logic valid);
    chk({tag, ".inst"}, bus.if_packet.inst, inst);
    chk({tag, ".pc"}, bus.if_packet.pc, pc);
    chk({tag, ".npc"}, bus.if_packet.npc, npc);
    chk({tag, ".valid"}, 32'(bus.if_packet.valid), 32'(valid));
  endtask
  initial begin
    bus.imem_req_ready = 1'b0; bus.imem_resp_valid = 1'b0; bus.imem_resp_data = '0;
    bus2.imem_req_ready = 1'b0; bus2.imem_resp_valid = 1'b0; bus2.imem_resp_data = '0;
    tick;
    chk("rst.req_valid", 32'(bus.imem_req_valid), 32'd0);
    chk_pkt("rst", NOP, 32'h0, 32'h4, 1'b0);
    rst = 1'b0;
    #1;
    chk("t1.req_valid", 32'(bus.imem_req_valid), 32'd1);
    chk("t1.addr0", bus.imem_req_addr, 32'h0);
    fetch(32'h0010_0093);
    chk_pkt("t1.p0", 32'h0010_0093, 32'h0, 32'h4, 1'b1);
    chk("t1.hold_noreq", 32'(bus.imem_req_valid), 32'd0);
    tick;
    chk_pkt("t1.consumed", NOP, 32'h0, 32'h4, 1'b0);
    chk("t1.addr4", bus.imem_req_addr, 32'h4);
    fetch(32'h0020_0113);
    chk_pkt("t1.p1", 32'h0020_0113, 32'h4, 32'h8, 1'b1);
    tick;
    fetch(32'h0030_0193);
    chk_pkt("t1.p2", 32'h0030_0193, 32'h8, 32'hC, 1'b1);
    tick;
    chk("t1.addr12", bus.imem_req_addr, 32'hC);
    fetch(32'hCAFE_0013);
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk_pkt("t2.stall", 32'hCAFE_0013, 32'hC, 32'h10, 1'b1);
      chk("t2.stall_noreq", 32'(bus.imem_req_valid), 32'd0);
    end
    stall = 1'b0;
    tick;
    chk("t2.valid_drop", 32'(bus.if_packet.valid), 32'd0);
    chk("t2.req_valid", 32'(bus.imem_req_valid), 32'd1);
    chk("t2.addr16", bus.imem_req_addr, 32'h10);
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("t3.req_valid", 32'(bus.imem_req_valid), 32'd1);
      chk("t3.addr", bus.imem_req_addr, 32'h10);
      chk("t3.no_pkt", 32'(bus.if_packet.valid), 32'd0);
    end
    fetch(32'h1111_1111);
    chk_pkt("t3.p", 32'h1111_1111, 32'h10, 32'h14, 1'b1);
    tick;
    bus.imem_req_ready = 1'b1;
    tick;
    bus.imem_req_ready = 1'b0;
    redir = 1'b1;
    rpc = 32'h203;
    tick;
    redir = 1'b0;
    #1;
    chk("t4.drain_noreq", 32'(bus.imem_req_valid), 32'd0);
    chk("t4.addr", bus.imem_req_addr, 32'h200);
    tick;
    chk("t4.drain_wait", 32'(bus.imem_req_valid), 32'd0);
    bus.imem_resp_valid = 1'b1;
    bus.imem_resp_data = 32'hDEAD_BEEF;
    tick;
    bus.imem_resp_valid = 1'b0;
    #1;
    chk("t4.discard", 32'(bus.if_packet.valid), 32'd0);
    chk("t4.req_valid", 32'(bus.imem_req_valid), 32'd1);
    chk("t4.req_addr", bus.imem_req_addr, 32'h200);
    fetch(32'h2222_2222);
    chk_pkt("t4.p", 32'h2222_2222, 32'h200, 32'h204, 1'b1);
    tick;
    bus.imem_req_ready = 1'b1;
    tick;
    bus.imem_req_ready = 1'b0;
    bus.imem_resp_valid = 1'b1;
    bus.imem_resp_data = 32'hBAD0_BAD0;
    redir = 1'b1;
    rpc = 32'h400;
    tick;
    bus.imem_resp_valid = 1'b0;
    redir = 1'b0;
    #1;
    chk_pkt("t5.drop", NOP, 32'h200, 32'h204, 1'b0);
    chk("t5.req_valid", 32'(bus.imem_req_valid), 32'd1);
    chk("t5.addr", bus.imem_req_addr, 32'h400);
    fetch(32'h3333_3333);
    chk_pkt("t5.p", 32'h3333_3333, 32'h400, 32'h404, 1'b1);
    stall = 1'b1;
    redir = 1'b1;
    rpc = 32'h81;
    tick;
    stall = 1'b0;
    redir = 1'b0;
    #1;
    chk("t5.hold_redir_valid", 32'(bus.if_packet.valid), 32'd0);
    chk("t5.hold_redir_inst", bus.if_packet.inst, NOP);
    chk("t5.hold_redir_req", 32'(bus.imem_req_valid), 32'd1);
    chk("t5.hold_redir_addr", bus.imem_req_addr, 32'h80);
    rst2 = 1'b0;
    bus2.imem_req_ready = 1'b1;
    #1;
    chk("t6.addr0", bus2.imem_req_addr, 32'hFFFF_FFFC);
    tick;
    bus2.imem_req_ready = 1'b0;
    bus2.imem_resp_valid = 1'b1;
    bus2.imem_resp_data = 32'h4444_4444;
    tick;
    bus2.imem_resp_valid = 1'b0;
    #1;
    chk("t6.pc", bus2.if_packet.pc, 32'hFFFF_FFFC);
    chk("t6.npc_wrap", bus2.if_packet.npc, 32'h0);
    tick;
    chk("t6.addr_wrap", bus2.imem_req_addr, 32'h0);
    bus2.imem_req_ready = 1'b1;
    tick;
    bus2.imem_req_ready = 1'b0;
    bus2.imem_resp_valid = 1'b1;
    bus2.imem_resp_data = 32'h5555_5555;
    tick;
    bus2.imem_resp_valid = 1'b0;
    stall2 = 1'b1;
    #1;
    chk("t6.p2_valid", 32'(bus2.if_packet.valid), 32'd1);
    chk("t6.p2_pc", bus2.if_packet.pc, 32'h0);
    rst2 = 1'b1;
    tick;
    chk("t6.rst_valid", 32'(bus2.if_packet.valid), 32'd0);
    chk("t6.rst_inst", bus2.if_packet.inst, NOP);
    chk("t6.rst_pc", bus2.if_packet.pc, 32'hFFFF_FFFC);
    chk("t6.rst_noreq", 32'(bus2.imem_req_valid), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cnt, errs);
    $finish;
  end
endmodule
